uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single UART transmit byte port among NREQ requesters
//  (e.g. Wishbone CPU path, logic-analyzer path, debug streams) inside the user project.
//  Packet-locked: the winner keeps the UART until it sends a byte flagged last.
//  Sits between the requesters and the UART TX holding interface in the user area.
// PARAMETERS
//  NREQ     4     number of requesters (2..8)
//  DW       8     byte width forwarded to the UART
//  TIMEOUT  1023  stall cycles before forced release (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//  wb_clk_i     in   1        system clock, all logic on rising edge
//  wb_rst_i     in   1        reset, asynchronous, active-high
//  req_valid_i  in   NREQ     requester i has a byte
//  req_data_i   in   NREQ*DW  requester i byte at [i*DW +: DW]
//  req_last_i   in   NREQ     requester i byte is last of packet
//  req_ready_o  out  NREQ     byte from requester i accepted this cycle (valid&ready)
//  tx_valid_o   out  1        byte offered to UART TX
//  tx_data_o    out  DW       byte to UART TX
//  tx_ready_i   in   1        UART TX accepts byte this cycle
//  grant_o      out  NREQ     one-hot current owner, 0 when idle
//  busy_o       out  1        1 while in GRANT
//  timeout_o    out  1        1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant_o=0, tx_valid_o=0,
//    tx_data_o=0, req_ready_o=0, busy_o=0, timeout_o=0, stall counter=0.
//  - States: IDLE, GRANT. grant register is the only source of ownership.
//  - IDLE: if |req_valid_i, winner g = first i with req_valid_i[i] searching rr_ptr,
//    rr_ptr+1, ... wrapping mod NREQ; register grant=1<<g, go GRANT. No valid: stay.
//  - Latency: req_valid_i rises at cycle n (in IDLE) -> grant_o/tx_valid_o at n+1.
//  - GRANT: tx_valid_o=req_valid_i[g], tx_data_o=req_data_i[g] (combinational from
//    registered grant); req_ready_o[g]=req_valid_i[g]&tx_ready_i, all other bits 0.
//    tx_data_o=0 whenever tx_valid_o=0.
//  - Transfer = tx_valid_o & tx_ready_i. Transfer with req_last_i[g]=1 -> IDLE next cycle,
//    grant cleared, rr_ptr=(g+1) mod NREQ. One idle cycle always separates packets.
//  - Requester g dropping valid mid-packet: grant held (packet lock), tx_valid_o=0.
//  - Requests from non-owners during GRANT are never forwarded and never acked; they
//    compete at the next IDLE. Simultaneous requests resolve purely by rr_ptr order.
//  - rr_ptr wraps NREQ-1 -> 0. Reset mid-packet aborts: grant and pointer cleared,
//    partial packet discarded; no byte is duplicated or acked after reset.
//  - Exactly one transfer per cycle max; at most one grant bit set at any time.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: stall counter (clog2(TIMEOUT+1) bits) runs in GRANT,
//    cleared on every transfer and on entry to GRANT; when it reaches TIMEOUT with no
//    transfer: grant released, state IDLE, rr_ptr=(g+1) mod NREQ, timeout_o=1 for one
//    cycle. A transfer in the same cycle as expiry wins: no timeout, counter cleared.
//  Not defined: no counter, timeout_o tied 0, grant held indefinitely until last byte.
// TESTING
//  1 Reset: assert wb_rst_i mid-packet, no clock edge -> all outputs 0 immediately;
//    after release, pending req0 granted from rr_ptr=0.
//  2 Req2 only, bytes A1,A2,A3 (last on A3), tx_ready_i=1 -> grant_o=4'b0100 one cycle
//    after valid, tx_data_o A1,A2,A3 on consecutive cycles, req_ready_o=4'b0100 each,
//    then grant_o=0, busy_o=0.
//  3 All four valid from reset, 1-byte packets, tx_ready_i=1 -> grant order 0,1,2,3,0,
//    one idle cycle between grants.
//  4 Req1 granted, tx_ready_i=0 for 5 cycles -> tx_valid_o=1, tx_data_o stable, req_ready_o=0;
//    on ready, single ack.
//  5 Req1 sends 4-byte packet while req0 valid throughout -> req0 never acked until req1
//    last byte accepted; next grant is req2 if valid else req3, else req0.
//  6 UART_ARB_TIMEOUT_EN, TIMEOUT=16, req3 granted, tx_ready_i=0 -> timeout_o pulse after
//    16 stall cycles, grant cleared, rr_ptr=0; without macro grant holds after 100 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the UART TX byte port among NREQ requesters.
// Define UART_ARB_TIMEOUT_EN to add a stall counter that forces release after TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    input  logic [NREQ-1:0]    req_last_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               tx_valid_o,
    output logic [DW-1:0]      tx_data_o,
    input  logic               tx_ready_i,
    output logic [NREQ-1:0]    grant_o,
    output logic               busy_o,
    output logic               timeout_o
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   pick;
    logic            xfer;
    logic [DW-1:0]   data_arr [NREQ];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   stall_q, stall_d;
    logic            timeout_q, timeout_d;
`endif

    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] ptr);
        logic [PW-1:0] sel;
        logic          found;
        int            s;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            if (!found && v[PW'(s)]) begin
                sel   = PW'(s);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [PW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
        return (g == PW'(NREQ - 1)) ? '0 : g + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data_i[i*DW +: DW];
        end
    end

    // Datapath is a pure mux off the registered grant; idle grant keeps every output quiet.
    always_comb begin
        owner       = onehot_idx(grant_q);
        pick        = rr_pick(req_valid_i, rr_ptr_q);
        tx_valid_o  = (|grant_q) && req_valid_i[owner];
        tx_data_o   = tx_valid_o ? data_arr[owner] : '0;
        req_ready_o = '0;
        xfer        = tx_valid_o && tx_ready_i;
        if (xfer) req_ready_o[owner] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    state_d       = GRANT;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_d       = '0;
`endif
                end
            end
            GRANT: begin
                if (xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (req_last_i[owner]) begin
                        grant_d  = '0;
                        state_d  = IDLE;
                        rr_ptr_d = ptr_after(owner);
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                // A transfer in the expiry cycle takes priority over the forced release.
                else if (stall_q == CW'(TIMEOUT)) begin
                    grant_d   = '0;
                    state_d   = IDLE;
                    rr_ptr_d  = ptr_after(owner);
                    stall_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == GRANT);
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: per-requester packet queues feed the DUT,
// a transaction-level arbitration model predicts ownership, and a monitor checks every transfer.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid_i = '0;
    logic [NREQ*DW-1:0] req_data_i = '0;
    logic [NREQ-1:0]    req_last_i = '0;
    logic [NREQ-1:0]    req_ready_o;
    logic               tx_valid_o;
    logic [DW-1:0]      tx_data_o;
    logic               tx_ready_i = 1'b0;
    logic [NREQ-1:0]    grant_o;
    logic               busy_o;
    logic               timeout_o;

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #10 clk = ~clk;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } xfer_t;

    logic [DW:0] pq [NREQ][$];   // {last, byte} per requester, whole packets only
    xfer_t       sb [$];
    xfer_t       mon_e;
    int          checks = 0;
    int          errors = 0;
    int          m_owner = -1;   // -1 = nobody owns the UART
    int          m_ptr = 0;
    int          m_stall = 0;
    bit          m_to = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int r, input int len);
        logic lb;
        for (int i = 0; i < len; i++) begin
            lb = (i == len - 1);
            pq[r].push_back({lb, 8'($urandom_range(0, 255))});
        end
    endtask

    // One clock of stimulus plus the reference prediction for that cycle.
    task automatic step(input int vld_pct, input int rdy_pct);
        logic [NREQ-1:0] v, l, eg, er;
        logic [DW-1:0]   d [NREQ];
        logic            ev;
        logic [DW-1:0]   ed;
        int              nxt, s;
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) begin
            if (pq[r].size() > 0) begin
                v[r] = ($urandom_range(0, 99) < vld_pct);
                d[r] = pq[r][0][DW-1:0];
                l[r] = pq[r][0][DW];
            end else begin
                v[r] = 1'b0;
                d[r] = 8'($urandom_range(0, 255));
                l[r] = 1'($urandom_range(0, 1));
            end
            req_data_i[r*DW +: DW] = d[r];
        end
        req_valid_i = v;
        req_last_i  = l;
        tx_ready_i  = ($urandom_range(0, 99) < rdy_pct);
        #2;
        eg = '0; er = '0; ev = 1'b0; ed = '0;
        if (m_owner >= 0) begin
            eg = 4'(1) << m_owner;
            ev = v[m_owner];
            if (ev) ed = d[m_owner];
            if (ev && tx_ready_i) er = 4'(1) << m_owner;
        end
        chk("grant", grant_o, eg);
        chk("busy", busy_o, (m_owner >= 0));
        chk("tx_valid", tx_valid_o, ev);
        chk("tx_data", tx_data_o, ed);
        chk("req_ready", req_ready_o, er);
        chk("timeout", timeout_o, m_to);
        m_to = 1'b0;
        if (m_owner < 0) begin
            nxt = -1;
            for (int k = 0; k < NREQ; k++) begin
                s = (m_ptr + k) % NREQ;
                if (nxt < 0 && v[s]) nxt = s;
            end
            m_owner = nxt;
            m_stall = 0;
        end else if (ev && tx_ready_i) begin
            sb.push_back('{m_owner, d[m_owner]});
            void'(pq[m_owner].pop_front());
            m_stall = 0;
            if (l[m_owner]) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            if (m_stall == TIMEOUT) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_stall++;
            end
`endif
        end
    endtask

    // Asserts reset between clock edges and checks outputs clear without any edge.
    task automatic apply_reset();
        #4;
        rst = 1'b1;
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_o, 0);
        for (int r = 0; r < NREQ; r++) pq[r].delete();
        sb.delete();
        m_owner = -1; m_ptr = 0; m_stall = 0; m_to = 1'b0;
        req_valid_i = '0; req_last_i = '0; req_data_i = '0; tx_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < NREQ; r++) if (pq[r].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: every accepted byte must match the oldest predicted transfer.
    always begin
        @(negedge clk);
        #4;
        if (!rst && tx_valid_o && tx_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got byte %0h with no predicted transfer at %0t", tx_data_o, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_data", tx_data_o, mon_e.data);
                chk("sb_ack", req_ready_o, 32'(1) << mon_e.idx);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        apply_reset();

        // Requester 2 alone sends A1 A2 A3.
        pq[2].push_back({1'b0, 8'hA1});
        pq[2].push_back({1'b0, 8'hA2});
        pq[2].push_back({1'b1, 8'hA3});
        repeat (6) step(100, 100);

        // All four ready from reset: order 0,1,2,3,0 with an idle cycle between.
        apply_reset();
        add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1); add_pkt(0, 1);
        repeat (12) step(100, 100);

        // Requester 1 held off by UART backpressure.
        add_pkt(1, 2);
        step(100, 100);
        repeat (5) step(100, 0);
        repeat (4) step(100, 100);

        // Requester 3 stalled for a long time: hold without timeout, forced release with it.
        add_pkt(3, 3);
        repeat (110) step(100, 0);
        repeat (8) step(100, 100);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (pq[r].size() < 6 && $urandom_range(0, 7) == 0) add_pkt(r, $urandom_range(1, 4));
            end
            step(75, 65);
        end

        // Reset in the middle of a packet, then pending requester 0 wins from pointer 0.
        add_pkt(1, 4);
        do step(100, 100); while (m_owner < 0 && pq[1].size() > 0);
        step(100, 100);
        apply_reset();
        add_pkt(0, 1);
        add_pkt(2, 1);
        repeat (6) step(100, 100);

        // Requester 1 four-byte packet while requester 0 waits; then 3, then 0.
        add_pkt(1, 4);
        add_pkt(0, 2);
        add_pkt(3, 1);
        repeat (14) step(100, 100);

        budget = 0;
        while ((!all_empty() || m_owner >= 0) && budget < 2000) begin
            step(100, 100);
            budget++;
        end
        repeat (2) step(100, 100);
        #4;
        checks++;
        if (budget >= 2000) begin
            errors++;
            $display("FAIL drain: got %0d cycles without draining, required below 2000", budget);
        end
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
